// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared constants and types for the multiplexed 7-segment scan controller.
package seg7_scan_ctrl_pkg;

    localparam int unsigned BCD_W = 4;
    localparam int unsigned SEG_W = 7;

    // Segments a..g on [6:0], active-low: all ones is a dark digit.
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

endpackage

// File: rtl/seg7_scan_ctrl_dec.sv
// BCD to active-low 7-segment decoder; codes 10..15 decode to a dark digit.
module seg7_scan_ctrl_dec
    import seg7_scan_ctrl_pkg::*;
(
    input  logic [BCD_W-1:0] bcd_i,
    output logic [SEG_W-1:0] seg_c_o
);

    always_comb begin
        seg_c_o = SEG_BLANK;
        case (bcd_i)
            4'd0:    seg_c_o = 7'b0000001;
            4'd1:    seg_c_o = 7'b1001111;
            4'd2:    seg_c_o = 7'b0010010;
            4'd3:    seg_c_o = 7'b0000110;
            4'd4:    seg_c_o = 7'b1001100;
            4'd5:    seg_c_o = 7'b0100100;
            4'd6:    seg_c_o = 7'b0100000;
            4'd7:    seg_c_o = 7'b0001111;
            4'd8:    seg_c_o = 7'b0000000;
            4'd9:    seg_c_o = 7'b0000100;
            default: seg_c_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode multi-digit 7-segment display,
// with inter-digit blanking, frame-aligned data updates and leading-zero suppression.
module seg7_scan_ctrl
    import seg7_scan_ctrl_pkg::*;
#(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned REFRESH_DIV   = 50000,
    parameter int unsigned BLANK_CYCLES  = 16,
    parameter int unsigned AN_ACTIVE_LOW = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          load,
    input  logic [BCD_W*NUM_DIGITS-1:0]   digits_in,
    input  logic [NUM_DIGITS-1:0]         dp_in,
    input  logic                          lz_blank_en,
    output logic [SEG_W-1:0]              seg,
    output logic                          dp,
    output logic [NUM_DIGITS-1:0]         an,
    output logic                          frame_done
);

    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
    localparam int unsigned CNT_W = $clog2(REFRESH_DIV);

    localparam logic [CNT_W-1:0]      CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0]      BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_OFF     = (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : '0;

    typedef logic [NUM_DIGITS-1:0][BCD_W-1:0] digits_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    pending_q, pending_d;
    digits_t                 shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    digits_t                 disp_q, disp_d;
    logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
    logic [SEG_W-1:0]        seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    frame_done_q, frame_done_d;

    logic                    slot_end;
    logic                    boundary;
    logic [BCD_W-1:0]        dec_bcd;
    logic [SEG_W-1:0]        dec_seg;
    logic [NUM_DIGITS-1:0]   lz_zero;
    logic [NUM_DIGITS-1:0]   an_hot;
    logic                    zero_run;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_BLANK;
        end else begin
            state_q <= state_d;
        end
    end

    // Slot sequencing: BLANK then SHOW within each REFRESH_DIV-clock slot.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        frame_done_d = 1'b0;
        slot_end     = (cnt_q == CNT_LAST);
        boundary     = 1'b0;
        if (!en) begin
            state_d = ST_BLANK;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            cnt_d = slot_end ? '0 : cnt_q + CNT_W'(1);
            case (state_q)
                ST_BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = ST_SHOW;
                    end
                end
                ST_SHOW: begin
                    if (slot_end) begin
                        state_d      = ST_BLANK;
                        boundary     = (idx_q == IDX_LAST);
                        idx_d        = boundary ? '0 : idx_q + IDX_W'(1);
                        frame_done_d = boundary;
                    end
                end
                default: state_d = ST_BLANK;
            endcase
        end
    end

    // Shadow capture and frame-aligned display update; a coincident load bypasses the shadow.
    always_comb begin
        shadow_d    = shadow_q;
        shadow_dp_d = shadow_dp_q;
        pending_d   = pending_q;
        disp_d      = disp_q;
        disp_dp_d   = disp_dp_q;
        if (load) begin
            shadow_d    = digits_in;
            shadow_dp_d = dp_in;
            pending_d   = 1'b1;
        end
        if (boundary) begin
            if (load) begin
                disp_d    = digits_in;
                disp_dp_d = dp_in;
            end else if (pending_q) begin
                disp_d    = shadow_q;
                disp_dp_d = shadow_dp_q;
            end
            pending_d = 1'b0;
        end
    end

    assign dec_bcd = disp_q[idx_d];

    seg7_scan_ctrl_dec u_dec (
        .bcd_i   (dec_bcd),
        .seg_c_o (dec_seg)
    );

    // Outputs follow the next state so anode and segments switch on the same edge.
    always_comb begin
        seg_d    = SEG_BLANK;
        dp_d     = 1'b1;
        an_d     = AN_OFF;
        lz_zero  = '0;
        zero_run = 1'b1;
        an_hot   = NUM_DIGITS'(1) << idx_d;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run   = zero_run & (disp_q[k] == '0);
            lz_zero[k] = zero_run;
        end
        if (state_d == ST_SHOW) begin
            seg_d = (lz_blank_en && (idx_d != '0) && lz_zero[idx_d]) ? SEG_BLANK : dec_seg;
            dp_d  = ~disp_dp_q[idx_d];
            an_d  = (AN_ACTIVE_LOW != 0) ? ~an_hot : an_hot;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q        <= '0;
            cnt_q        <= '0;
            pending_q    <= 1'b0;
            shadow_q     <= '0;
            shadow_dp_q  <= '0;
            disp_q       <= '0;
            disp_dp_q    <= '0;
            seg_q        <= SEG_BLANK;
            dp_q         <= 1'b1;
            an_q         <= AN_OFF;
            frame_done_q <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            pending_q    <= pending_d;
            shadow_q     <= shadow_d;
            shadow_dp_q  <= shadow_dp_d;
            disp_q       <= disp_d;
            disp_dp_q    <= disp_dp_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule
